// File: rtl/in_polygon_seq_if.sv
// Query/result bundle for in_polygon_seq. The signal names match the flat port list of the
// original block. on_edge_out is present only when IN_POLYGON_SEQ_ON_EDGE_EN is defined.
interface in_polygon_seq_if #(
  parameter int WORLD_BITS       = 32,
  parameter int MAX_NUM_VERTICES = 32
);
  logic signed [WORLD_BITS-1:0]             x_in;
  logic signed [WORLD_BITS-1:0]             y_in;
  logic signed [WORLD_BITS-1:0]             poly_xs_in [MAX_NUM_VERTICES];
  logic signed [WORLD_BITS-1:0]             poly_ys_in [MAX_NUM_VERTICES];
  logic [$clog2(MAX_NUM_VERTICES+1)-1:0]    num_points_in;
  logic                                     valid_in;
  logic                                     ready_out;
  logic                                     inside_out;
  logic                                     valid_out;
  logic                                     ready_in;
  logic                                     busy_out;
`ifdef IN_POLYGON_SEQ_ON_EDGE_EN
  logic                                     on_edge_out;

  modport master (
    output x_in, y_in, poly_xs_in, poly_ys_in, num_points_in, valid_in, ready_in,
    input  ready_out, inside_out, valid_out, busy_out, on_edge_out
  );
  modport slave (
    input  x_in, y_in, poly_xs_in, poly_ys_in, num_points_in, valid_in, ready_in,
    output ready_out, inside_out, valid_out, busy_out, on_edge_out
  );
`else
  modport master (
    output x_in, y_in, poly_xs_in, poly_ys_in, num_points_in, valid_in, ready_in,
    input  ready_out, inside_out, valid_out, busy_out
  );
  modport slave (
    input  x_in, y_in, poly_xs_in, poly_ys_in, num_points_in, valid_in, ready_in,
    output ready_out, inside_out, valid_out, busy_out
  );
`endif
endinterface

// File: rtl/in_polygon_seq.sv
// Time-multiplexed even-odd point-in-polygon test. It evaluates LANES edges per SCAN cycle
// through a 2-stage edge pipeline. IN_POLYGON_SEQ_ON_EDGE_EN adds boundary detection.
module in_polygon_seq #(
  parameter int WORLD_BITS       = 32,
  parameter int MAX_NUM_VERTICES = 32,
  parameter int LANES            = 4
) (
  input  logic            clk_in,
  input  logic            rst_in,
  in_polygon_seq_if.slave bus
);
  localparam int IW = $clog2(MAX_NUM_VERTICES + LANES + 1) + 1;
  localparam int DW = WORLD_BITS + 1;
  localparam int PW = 2 * WORLD_BITS + 3;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t state_q, state_d;
  logic [IW-1:0] k_q, k_d;
  logic [IW-1:0] neff_q, neff_in, n_raw;
  logic          drain_q, drain_d;
  logic          parity_q, parity_d;
  logic          cross_q;
  logic          accept;
  logic [LANES-1:0] cross_w;

  logic signed [WORLD_BITS-1:0] x_q, y_q;
  logic signed [WORLD_BITS-1:0] vx_q [MAX_NUM_VERTICES];
  logic signed [WORLD_BITS-1:0] vy_q [MAX_NUM_VERTICES];

`ifdef IN_POLYGON_SEQ_ON_EDGE_EN
  logic             hit_q;
  logic             onedge_q, onedge_d;
  logic [LANES-1:0] edge_w;
`endif

  function automatic logic signed [DW-1:0] sx(input logic signed [WORLD_BITS-1:0] v);
    return {v[WORLD_BITS-1], v};
  endfunction

  function automatic logic signed [PW-1:0] ext(input logic signed [DW-1:0] v);
    return {{(PW-DW){v[DW-1]}}, v};
  endfunction

  always_comb begin
    n_raw   = IW'(bus.num_points_in);
    neff_in = (n_raw > IW'(MAX_NUM_VERTICES)) ? IW'(MAX_NUM_VERTICES) : n_raw;
  end

  always_comb begin
    state_d        = state_q;
    k_d            = k_q;
    drain_d        = drain_q;
    accept         = 1'b0;
    bus.ready_out  = 1'b0;
    bus.valid_out  = 1'b0;
    bus.busy_out   = 1'b1;
    bus.inside_out = 1'b0;
`ifdef IN_POLYGON_SEQ_ON_EDGE_EN
    bus.on_edge_out = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        bus.ready_out = 1'b1;
        bus.busy_out  = 1'b0;
        if (bus.valid_in) begin
          accept  = 1'b1;
          state_d = SCAN;
          k_d     = '0;
        end
      end
      SCAN: begin
        k_d = k_q + IW'(LANES);
        // The last batch is issued when it covers n_eff, so n_eff==0 still takes one cycle.
        if (k_q + IW'(LANES) >= neff_q) begin
          state_d = DRAIN;
          drain_d = 1'b0;
        end
      end
      DRAIN: begin
        if (drain_q) state_d = DONE;
        else         drain_d = 1'b1;
      end
      DONE: begin
        bus.valid_out = 1'b1;
`ifdef IN_POLYGON_SEQ_ON_EDGE_EN
        bus.inside_out  = parity_q | onedge_q;
        bus.on_edge_out = onedge_q;
`else
        bus.inside_out = parity_q;
`endif
        if (bus.ready_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    parity_d = accept ? 1'b0 : (parity_q ^ cross_q);
`ifdef IN_POLYGON_SEQ_ON_EDGE_EN
    onedge_d = accept ? 1'b0 : (onedge_q | hit_q);
`endif
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= IDLE;
      k_q      <= '0;
      drain_q  <= 1'b0;
      parity_q <= 1'b0;
      cross_q  <= 1'b0;
`ifdef IN_POLYGON_SEQ_ON_EDGE_EN
      onedge_q <= 1'b0;
      hit_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      drain_q  <= drain_d;
      parity_q <= parity_d;
      cross_q  <= ^cross_w;
`ifdef IN_POLYGON_SEQ_ON_EDGE_EN
      onedge_q <= onedge_d;
      hit_q    <= |edge_w;
`endif
    end
  end

  always_ff @(posedge clk_in) begin
    if (accept) begin
      x_q    <= bus.x_in;
      y_q    <= bus.y_in;
      vx_q   <= bus.poly_xs_in;
      vy_q   <= bus.poly_ys_in;
      neff_q <= neff_in;
    end
  end

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic [IW-1:0]                ia, ib;
    logic signed [WORLD_BITS-1:0] ax, ay, bx, by, hx, hy, lx, ly;
    logic                         v_d, inb_d, v_q, inb_q;
    logic signed [DW-1:0]         dlx_d, dyq_d, dly_d, dxq_d;
    logic signed [DW-1:0]         dlx_q, dyq_q, dly_q, dxq_q;
    logic signed [PW-1:0]         d;
`ifdef IN_POLYGON_SEQ_ON_EDGE_EN
    logic                         box_d, box_q;
`endif

    // S1: pick the edge endpoints, order them by y and form the four differences.
    always_comb begin
      ia  = k_q + IW'(j);
      ib  = (ia + IW'(1) == neff_q) ? '0 : ia + IW'(1);
      v_d = (state_q == SCAN) && (neff_q >= IW'(3)) && (ia < neff_q);
      ax  = '0;
      ay  = '0;
      bx  = '0;
      by  = '0;
      for (int unsigned v = 0; v < MAX_NUM_VERTICES; v++) begin
        if (ia == IW'(v)) begin
          ax = vx_q[v];
          ay = vy_q[v];
        end
        if (ib == IW'(v)) begin
          bx = vx_q[v];
          by = vy_q[v];
        end
      end
      if (ay > by) begin
        hx = ax; hy = ay; lx = bx; ly = by;
      end else begin
        hx = bx; hy = by; lx = ax; ly = ay;
      end
      dlx_d = sx(lx) - sx(hx);
      dyq_d = sx(y_q) - sx(hy);
      dly_d = sx(ly) - sx(hy);
      dxq_d = sx(x_q) - sx(hx);
      inb_d = (hy > y_q) && (y_q >= ly);
`ifdef IN_POLYGON_SEQ_ON_EDGE_EN
      box_d = (y_q >= ly) && (y_q <= hy) &&
              (x_q >= ((hx < lx) ? hx : lx)) && (x_q <= ((hx < lx) ? lx : hx));
`endif
    end

    always_ff @(posedge clk_in) begin
      if (rst_in) v_q <= 1'b0;
      else        v_q <= v_d;
      inb_q <= inb_d;
      dlx_q <= dlx_d;
      dyq_q <= dyq_d;
      dly_q <= dly_d;
      dxq_q <= dxq_d;
`ifdef IN_POLYGON_SEQ_ON_EDGE_EN
      box_q <= box_d;
`endif
    end

    // S2: the full-width cross product cannot overflow, so its sign bit is exact.
    assign d          = ext(dlx_q) * ext(dyq_q) - ext(dly_q) * ext(dxq_q);
    assign cross_w[j] = v_q & inb_q & ~d[PW-1];
`ifdef IN_POLYGON_SEQ_ON_EDGE_EN
    assign edge_w[j]  = v_q & box_q & (d == '0);
`endif
  end

endmodule

// File: tb/tb_in_polygon_seq.sv
// Directed self-checking bench for in_polygon_seq. It uses one LANES=4 instance and one
// LANES=3 instance that share the clock and the reset.
module tb_in_polygon_seq;
  localparam int W    = 16;
  localparam int MAXV = 8;
  localparam int NW   = $clog2(MAXV + 1);

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   fails  = 0;
  int   px [MAXV];
  int   py [MAXV];
`ifdef IN_POLYGON_SEQ_ON_EDGE_EN
  logic last_oe;
`endif

  in_polygon_seq_if #(.WORLD_BITS(W), .MAX_NUM_VERTICES(MAXV)) b4 ();
  in_polygon_seq_if #(.WORLD_BITS(W), .MAX_NUM_VERTICES(MAXV)) b3 ();

  in_polygon_seq #(.WORLD_BITS(W), .MAX_NUM_VERTICES(MAXV), .LANES(4)) u4 (
    .clk_in(clk), .rst_in(rst), .bus(b4));
  in_polygon_seq #(.WORLD_BITS(W), .MAX_NUM_VERTICES(MAXV), .LANES(3)) u3 (
    .clk_in(clk), .rst_in(rst), .bus(b3));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic f_ready(input int sel);
    return (sel == 4) ? b4.ready_out : b3.ready_out;
  endfunction
  function automatic logic f_valid(input int sel);
    return (sel == 4) ? b4.valid_out : b3.valid_out;
  endfunction
  function automatic logic f_inside(input int sel);
    return (sel == 4) ? b4.inside_out : b3.inside_out;
  endfunction
  function automatic logic f_busy(input int sel);
    return (sel == 4) ? b4.busy_out : b3.busy_out;
  endfunction

  task automatic set_rin(input int sel, input logic r);
    if (sel == 4) b4.ready_in = r;
    else          b3.ready_in = r;
  endtask

  // scr replaces the polygon with unrelated values to show that accepted queries are isolated.
  task automatic drive(input int sel, input int qx, input int qy, input int n,
                       input logic v, input logic scr);
    if (sel == 4) begin
      b4.x_in = W'(qx);
      b4.y_in = W'(qy);
      b4.num_points_in = NW'(n);
      b4.valid_in = v;
      for (int i = 0; i < MAXV; i++) begin
        b4.poly_xs_in[i] = scr ? W'(i * 5 + 3) : W'(px[i]);
        b4.poly_ys_in[i] = scr ? W'(40 - i * 9) : W'(py[i]);
      end
    end else begin
      b3.x_in = W'(qx);
      b3.y_in = W'(qy);
      b3.num_points_in = NW'(n);
      b3.valid_in = v;
      for (int i = 0; i < MAXV; i++) begin
        b3.poly_xs_in[i] = scr ? W'(i * 5 + 3) : W'(px[i]);
        b3.poly_ys_in[i] = scr ? W'(40 - i * 9) : W'(py[i]);
      end
    end
  endtask

  // Unused slots hold filler vertices. Only edge 4->5 crosses y=5, so a missing lane mask flips parity.
  task automatic load_square(input int x0, input int y0, input int s);
    for (int i = 0; i < MAXV; i++) begin
      px[i] = -100 - i;
      py[i] = (i == 4) ? -50 : 60;
    end
    px[0] = x0;     py[0] = y0;
    px[1] = x0 + s; py[1] = y0;
    px[2] = x0 + s; py[2] = y0 + s;
    px[3] = x0;     py[3] = y0 + s;
  endtask

  task automatic load_u();
    px[0] = 0;  py[0] = 0;
    px[1] = 30; py[1] = 0;
    px[2] = 30; py[2] = 30;
    px[3] = 20; py[3] = 30;
    px[4] = 20; py[4] = 10;
    px[5] = 10; py[5] = 10;
    px[6] = 10; py[6] = 30;
    px[7] = 0;  py[7] = 30;
  endtask

  task automatic load_tri();
    load_square(0, 0, 10);
    px[2] = 0; py[2] = 10;
  endtask

  // lat counts rising edges from the accepting edge through the edge that raises valid_out.
  task automatic query(input int sel, input int qx, input int qy, input int n,
                       input logic exp_in, input int exp_lat, input int hold, input string tag);
    int lat;
    int guard;
    logic held_in;
    guard = 0;
    while (!f_ready(sel) && guard < 100) begin
      tick();
      guard++;
    end
    check({tag, "_ready_before"}, f_ready(sel), 1);
    set_rin(sel, hold == 0);
    drive(sel, qx, qy, n, 1'b1, 1'b0);
    tick();
    drive(sel, qx + 7, qy - 3, 1, 1'b0, 1'b1);
    lat = 1;
    check({tag, "_ready_busy_after_accept"}, {f_ready(sel), f_busy(sel)}, 2'b01);
    while (!f_valid(sel) && lat < 60) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_inside"}, f_inside(sel), exp_in);
`ifdef IN_POLYGON_SEQ_ON_EDGE_EN
    last_oe = (sel == 4) ? b4.on_edge_out : b3.on_edge_out;
`endif
    held_in = f_inside(sel);
    for (int c = 0; c < hold; c++) begin
      tick();
      check({tag, "_hold_valid_inside_ready"}, {f_valid(sel), f_inside(sel), f_ready(sel)},
            {1'b1, held_in, 1'b0});
    end
    set_rin(sel, 1'b1);
    tick();
    check({tag, "_ready_valid_after_handshake"}, {f_ready(sel), f_valid(sel)}, 2'b10);
  endtask

  initial begin
    rst = 1'b1;
    b4.ready_in = 1'b1;
    b3.ready_in = 1'b1;
    load_square(0, 0, 10);
    drive(4, 0, 0, 0, 1'b0, 1'b0);
    drive(3, 0, 0, 0, 1'b0, 1'b0);
    repeat (3) tick();
    check("reset_u4_ready_valid_inside_busy",
          {b4.ready_out, b4.valid_out, b4.inside_out, b4.busy_out}, 4'b1000);
    check("reset_u3_ready_valid_inside_busy",
          {b3.ready_out, b3.valid_out, b3.inside_out, b3.busy_out}, 4'b1000);
    rst = 1'b0;
    tick();

    load_square(0, 0, 10);
    query(4, 5, 5, 4, 1'b1, 4, 0, "sq4_center");
    query(4, 15, 5, 4, 1'b0, 4, 0, "sq4_right_outside");
    query(4, 5, 5, 2, 1'b0, 4, 0, "sq4_n2");
    query(4, 5, 5, 0, 1'b0, 4, 0, "sq4_n0");
    query(4, 5, 5, 4, 1'b1, 4, 10, "sq4_backpressure");
    query(3, 5, 5, 4, 1'b1, 5, 0, "sq3_center_masked_lanes");

    load_square(-10, -10, 8);
    query(4, -5, -5, 4, 1'b1, 4, 0, "neg_sq_inside");
    query(4, -1, -5, 4, 1'b0, 4, 0, "neg_sq_outside");

    load_tri();
    query(3, 2, 2, 3, 1'b1, 4, 0, "tri_n3_inside");

    load_u();
    query(3, 15, 20, 8, 1'b0, 6, 0, "u3_notch");
    query(3, 5, 20, 8, 1'b1, 6, 0, "u3_arm");
    query(4, 5, 20, 8, 1'b1, 5, 0, "u4_arm");
    query(3, 5, 20, 15, 1'b1, 6, 0, "u3_clamp_n");

    // Abandon a query in SCAN, then confirm the next one starts clean.
    drive(3, 5, 20, 8, 1'b1, 1'b0);
    tick();
    drive(3, 0, 0, 8, 1'b0, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_scan_ready_valid_busy", {b3.ready_out, b3.valid_out, b3.busy_out}, 3'b100);
    load_u();
    query(3, 15, 20, 8, 1'b0, 6, 0, "post_rst_notch");
    query(3, 5, 20, 8, 1'b1, 6, 0, "post_rst_arm");

`ifdef IN_POLYGON_SEQ_ON_EDGE_EN
    load_square(0, 0, 10);
    query(4, 10, 5, 4, 1'b1, 4, 0, "oe_boundary");
    check("oe_boundary_flag", last_oe, 1);
    query(4, 5, 5, 4, 1'b1, 4, 0, "oe_interior");
    check("oe_interior_flag", last_oe, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/in_polygon_seq.md
Name: in_polygon_seq

Overview:
Handshaked, time-multiplexed point-in-polygon tester; parametrised successor to the fully parallel in-polygon block. Evaluates LANES polygon edges per cycle using even-odd ray crossing (ray cast toward −x). Lets the physics/render pipeline trade area against latency and tolerates downstream backpressure. Sits between the world-geometry store and the collision/fill consumers.

Parameters:
WORLD_BITS, 32, signed coordinate width
MAX_NUM_VERTICES, 32, vertex array depth
LANES, 4, edges evaluated per SCAN cycle; 1..MAX_NUM_VERTICES

Ports:
clk_in  input  1  clock
rst_in  input  1  reset
x_in  input  WORLD_BITS signed  query x
y_in  input  WORLD_BITS signed  query y
poly_xs_in  input  WORLD_BITS signed x MAX_NUM_VERTICES  vertex x array
poly_ys_in  input  WORLD_BITS signed x MAX_NUM_VERTICES  vertex y array
num_points_in  input  $clog2(MAX_NUM_VERTICES+1)  vertex count n
valid_in  input  1  query valid
ready_out  output  1  block can accept a query
inside_out  output  1  result: point inside polygon
valid_out  output  1  result valid
ready_in  input  1  consumer accepts result
busy_out  output  1  query in flight

Behaviour:
- Clocking and reset: one clock, clk_in; rst_in is synchronous, active-high. Reset values: ready_out=1, valid_out=0, inside_out=0, busy_out=0, FSM=IDLE, parity=0. Reset mid-operation abandons the query and emits no result.
- FSM states: IDLE, SCAN, DRAIN, DONE.
- IDLE: ready_out=1. When valid_in&ready_out, register x, y, all vertices and n_eff = min(n, MAX_NUM_VERTICES). Then go to SCAN with k=0 and parity cleared.
- SCAN: issue edges k..k+LANES-1. Edge i runs from vertex i to vertex (i+1 == n_eff ? 0 : i+1). Lanes with i ≥ n_eff are masked. k += LANES each cycle. Stay for B = max(1, ceil(n_eff/LANES)) cycles, then go to DRAIN.
- n_eff < 3: all lanes are masked, so the result is 0.
- Edge pipeline, 2 stages:
  - S1: H = endpoint with larger y (ties: second vertex is H). L = the other endpoint. Compute the four differences at WORLD_BITS+1 bits. in_bounds = (Hy > y) && (y >= Ly).
  - S2: d = (Lx−Hx)(y−Hy) − (Ly−Hy)(x−Hx), computed at 2*WORLD_BITS+3 bits signed, so no overflow. crossing = in_bounds && d ≥ 0. parity ^= XOR of all unmasked lane crossings.
- DRAIN: 2 cycles to flush S1/S2, then go to DONE.
- DONE: valid_out=1 and inside_out=parity. Both are held stable while ready_in=0. On valid_out&ready_in, go to IDLE; ready_out rises the following cycle.
- Latency: valid_out rises exactly B+3 cycles after the accepting edge.
- Throughput: one query per B+4 cycles with ready_in tied high.
- busy_out=1 in SCAN, DRAIN and DONE.
- ready_out=0 outside IDLE. valid_in is ignored outside IDLE.
- Query inputs may change freely after acceptance without affecting the result.
- Horizontal edges never satisfy in_bounds.
- Result with the query point exactly on an edge is implementation-defined unless ON_EDGE_EN is defined.

Optional Feature:
Macro: IN_POLYGON_SEQ_ON_EDGE_EN.
- Defined: adds port on_edge_out (output, 1 bit), registered with inside_out and valid under valid_out, reset 0.
  - An edge flags on_edge when all of the following hold: d == 0, min(Hy,Ly) ≤ y ≤ max(Hy,Ly), and min(Hx,Lx) ≤ x ≤ max(Hx,Lx).
  - on_edge_out = OR over unmasked edges.
  - inside_out is forced to 1 when on_edge_out is 1.
  - Latency is unchanged.
- Undefined: no port and no extra logic; behaviour is exactly as above.

Test Plan:
- Square (0,0),(10,0),(10,10),(0,10); n=4, LANES=4; query (5,5) → inside_out=1, valid_out exactly 4 cycles after accept. Query (15,5) → 0.
- Concave U-shape (0,0),(30,0),(30,30),(20,30),(20,10),(10,10),(10,30),(0,30); n=8, LANES=3; query (15,20) → 0 and query (5,20) → 1. B=3, so latency is 6.
- n=2 and n=0 with arbitrary vertices → inside_out=0, latency 4. num_points_in=MAX_NUM_VERTICES+… clamps to MAX_NUM_VERTICES.
- Backpressure: hold ready_in=0 for 10 cycles in DONE → valid_out and inside_out stay stable and ready_out stays 0. Release → one handshake, then ready_out=1 the next cycle.
- Assert rst_in during SCAN → next cycle ready_out=1, valid_out=0. A fresh query then gives the correct result with no stale parity.
- With IN_POLYGON_SEQ_ON_EDGE_EN: square query (10,5) → on_edge_out=1 and inside_out=1. Query (5,5) → on_edge_out=0.
